regfile_debug_ctrl: RTL and testbench
=====================================

# regfile_debug_ctrl

UART-driven debug controller that gives a host PC read and write access to the 16×16 CPU register file. It parses command bytes from the UART receiver and halts the CPU with a request/acknowledge handshake. While the CPU is halted, it takes over the register-file read port 1 and write port, then returns response bytes to the UART transmitter. It sits between the UART RX/TX blocks, the CPU control path and the register file's port inputs.

## Interface
- DATA_W, 16, register width
- ADDR_W, 4, register address width
- HALT_TIMEOUT, 255, cycles to wait for halt acknowledge before NAK
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_rx_valid  in  1  one-cycle strobe, received byte valid
- i_rx_data  in  8  received byte
- o_tx_valid  out  1  response byte valid
- o_tx_data  out  8  response byte
- i_tx_ready  in  1  transmitter accepts byte on this edge
- o_halt_req  out  1  request CPU halt
- i_halt_ack  in  1  CPU halted and pipeline drained
- i_cpu_write_en / i_cpu_write_add / i_cpu_write_data  in  1/ADDR_W/DATA_W  CPU write-port request
- i_cpu_read_add1  in  ADDR_W  CPU read-port-1 address
- o_rf_write_en / o_rf_write_add / o_rf_write_data  out  1/ADDR_W/DATA_W  muxed register-file write port
- o_rf_read_add1  out  ADDR_W  muxed register-file read address 1
- i_rf_read_data1  in  DATA_W  register-file read data 1 (combinational)
- o_busy  out  1  command in progress
- o_err  out  1  one-cycle pulse on protocol error

## Operation
- Command byte: [7:4] opcode, [3:0] register A.
  - 0x1 = read: response is two bytes, hi then lo.
  - 0x2 = write: followed by data hi then data lo bytes; response is 0xA5.
  - Any other opcode: response 0xEE (NAK) and an o_err pulse.
- States: IDLE, GET_HI, GET_LO, HALT, ACCESS, COMMIT, TX_HI, TX_LO, TX_ACK, RELEASE.
- IDLE + rx byte:
  - Opcode 0x1 → HALT.
  - Opcode 0x2 → GET_HI → GET_LO → HALT.
  - Other opcode → TX_ACK carrying 0xEE.
- HALT: o_halt_req=1. Timeout counter counts up each cycle.
  - i_halt_ack sampled high → ACCESS, and the own flag is set.
  - Counter reaches HALT_TIMEOUT → TX_ACK carrying 0xEE, o_err pulse, o_halt_req drops.
- Port mux: own flag = 1 selects debug values; own = 0 passes the CPU port signals through unchanged. o_rf_write_en is forced 0 while own=1, except in COMMIT.
- ACCESS:
  - Read: o_rf_read_add1=A, i_rf_read_data1 captured on the edge leaving ACCESS → TX_HI.
  - Write: → COMMIT.
- COMMIT: o_rf_write_en=1, o_rf_write_add=A, o_rf_write_data={hi,lo} for exactly one cycle → TX_ACK carrying 0xA5.
- TX_HI / TX_LO / TX_ACK: o_tx_valid held high with o_tx_data stable until the edge on which i_tx_ready=1. Then advance:
  - TX_HI → TX_LO.
  - TX_LO → RELEASE.
  - TX_ACK → RELEASE if the halt was taken, otherwise IDLE.
- RELEASE: own flag cleared, o_halt_req=0 → IDLE.
- Rx bytes arriving outside IDLE/GET_HI/GET_LO are dropped and pulse o_err. The current command continues.
- o_busy = 1 in every state except IDLE.

## Timing
- Reset (async assert): every output is 0, the own flag is 0 and the FSM is in IDLE. A reset mid-command releases halt immediately and discards the command.
- The register file writes on the falling edge. COMMIT's one-cycle write_en is therefore captured mid-cycle.
- Read latency from command byte to o_tx_valid (hi byte): 1 (HALT) + ack wait + 1 (ACCESS) + 1 cycles, with ack immediate → 3 cycles.
- o_halt_req rises the cycle after the triggering rx byte. It falls the cycle after the last response byte is accepted.
- The own flag changes only on rising edges while i_halt_ack=1. The CPU must not drop i_halt_ack while o_halt_req=1.

## Configuration
- REGDBG_DUMP_EN defined:
  - Opcode 0x3 (A ignored) halts once and reads registers 0..15 in order.
  - Sends 32 bytes, hi/lo per register, using a 4-bit counter that wraps to end the dump at register 15.
- REGDBG_DUMP_EN undefined: opcode 0x3 is NAKed like any unknown opcode.

## Structure
- Package regdbg_pkg holds:
  - The state enum.
  - Opcode constants OP_READ=4'h1, OP_WRITE=4'h2, OP_DUMP=4'h3.
  - Response constants RSP_ACK=8'hA5, RSP_NAK=8'hEE.
- Sub-module regdbg_port_mux: purely combinational CPU/debug port selection driven by the own flag. The FSM, counters and TX logic stay in the top.

## Test plan
- Rx 0x2C, 0x12, 0x34 with ack 2 cycles after request → single write_en cycle with add=0xC, data=0x1234, then tx 0xA5; halt_req low afterwards.
- Preload R5=0xBEEF via the CPU port, then rx 0x15 → tx 0xBE then 0xEF. CPU port signals pass through before and after the command.
- Rx 0x13 with i_halt_ack never asserted → after 255 cycles tx 0xEE, o_err pulse, halt_req=0, no RF write.
- Rx 0x70 → tx 0xEE and o_err, with halt_req never asserted.
- During COMMIT with i_tx_ready held low, assert reset → all outputs 0 at once; after reset release, a new read works.
- With REGDBG_DUMP_EN, rx 0x30 → 32 tx bytes matching R0..R15, with one halt/release pair.

Source files
------------

// File: rtl/regdbg_pkg.sv
// Shared types and constants for the UART register-file debug controller.
// Command byte is {opcode, register}; responses are single bytes.
package regdbg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_HI,
    GET_LO,
    HALT,
    ACCESS,
    COMMIT,
    TX_HI,
    TX_LO,
    TX_ACK,
    RELEASE
  } state_t;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_DUMP  = 4'h3;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_NAK = 8'hEE;

endpackage

// File: rtl/regdbg_port_mux.sv
// Combinational CPU/debug selection of register-file write port and read port 1.
// Zero latency; the debug side owns the ports only while own=1.
module regdbg_port_mux #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              own,
  input  logic              dbg_write_en,
  input  logic [ADDR_W-1:0] dbg_add,
  input  logic [DATA_W-1:0] dbg_write_data,
  input  logic              cpu_write_en,
  input  logic [ADDR_W-1:0] cpu_write_add,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic [ADDR_W-1:0] cpu_read_add1,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_add,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_add1
);

  assign rf_write_en   = own ? dbg_write_en   : cpu_write_en;
  assign rf_write_add  = own ? dbg_add        : cpu_write_add;
  assign rf_write_data = own ? dbg_write_data : cpu_write_data;
  assign rf_read_add1  = own ? dbg_add        : cpu_read_add1;

endmodule

// File: rtl/regfile_debug_ctrl.sv
// UART debug controller: halts the CPU, reads/writes one register; REGDBG_DUMP_EN adds opcode 0x3 full dump.
// Read response starts 3 cycles after the command byte with immediate ack; TX bytes held until i_tx_ready.
module regfile_debug_ctrl
  import regdbg_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_halt_req,
  input  logic              i_halt_ack,
  input  logic              i_cpu_write_en,
  input  logic [ADDR_W-1:0] i_cpu_write_add,
  input  logic [DATA_W-1:0] i_cpu_write_data,
  input  logic [ADDR_W-1:0] i_cpu_read_add1,
  output logic              o_rf_write_en,
  output logic [ADDR_W-1:0] o_rf_write_add,
  output logic [DATA_W-1:0] o_rf_write_data,
  output logic [ADDR_W-1:0] o_rf_read_add1,
  input  logic [DATA_W-1:0] i_rf_read_data1,
  output logic              o_busy,
  output logic              o_err
);

  localparam int TO_W = $clog2(HALT_TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] reg_a;
  logic [15:0]       data_buf;
  logic [TO_W-1:0]   to_cnt;
  logic              own;
  logic              commit_en;
  logic              is_write;
  logic              is_dump;

  logic [3:0]        op;
  logic [15:0]       rd16;
  logic [ADDR_W-1:0] reg_a_nxt;

  assign op        = i_rx_data[7:4];
  assign rd16      = i_rf_read_data1[15:0];
  assign reg_a_nxt = reg_a + 1'b1;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      reg_a      <= '0;
      data_buf   <= '0;
      to_cnt     <= '0;
      own        <= 1'b0;
      commit_en  <= 1'b0;
      is_write   <= 1'b0;
      is_dump    <= 1'b0;
      o_halt_req <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err     <= 1'b0;
      commit_en <= 1'b0;
      // Bytes arriving mid-command are discarded; the command keeps running.
      if (i_rx_valid && !(state inside {IDLE, GET_HI, GET_LO}))
        o_err <= 1'b1;

      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            reg_a    <= ADDR_W'(i_rx_data[3:0]);
            to_cnt   <= '0;
            is_write <= (op == OP_WRITE);
            is_dump  <= 1'b0;
            case (op)
              OP_READ: begin
                o_halt_req <= 1'b1;
                state      <= HALT;
              end
              OP_WRITE: state <= GET_HI;
`ifdef REGDBG_DUMP_EN
              OP_DUMP: begin
                reg_a      <= '0;
                is_dump    <= 1'b1;
                o_halt_req <= 1'b1;
                state      <= HALT;
              end
`endif
              default: begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= RSP_NAK;
                o_err      <= 1'b1;
                state      <= TX_ACK;
              end
            endcase
          end
        end
        GET_HI: begin
          if (i_rx_valid) begin
            data_buf[15:8] <= i_rx_data;
            state          <= GET_LO;
          end
        end
        GET_LO: begin
          if (i_rx_valid) begin
            data_buf[7:0] <= i_rx_data;
            o_halt_req    <= 1'b1;
            state         <= HALT;
          end
        end
        HALT: begin
          if (i_halt_ack) begin
            own   <= 1'b1;
            state <= ACCESS;
          end else if (to_cnt == TO_W'(HALT_TIMEOUT - 1)) begin
            o_halt_req <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= RSP_NAK;
            o_err      <= 1'b1;
            state      <= TX_ACK;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (is_write) begin
            commit_en <= 1'b1;
            state     <= COMMIT;
          end else begin
            // Low byte parked in data_buf until the high byte is accepted.
            o_tx_valid    <= 1'b1;
            o_tx_data     <= rd16[15:8];
            data_buf[7:0] <= rd16[7:0];
            state         <= TX_HI;
          end
        end
        COMMIT: begin
          o_tx_valid <= 1'b1;
          o_tx_data  <= RSP_ACK;
          state      <= TX_ACK;
        end
        TX_HI: begin
          if (i_tx_ready) begin
            o_tx_data <= data_buf[7:0];
            state     <= TX_LO;
          end
        end
        TX_LO: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (is_dump && reg_a_nxt != '0) begin
              reg_a <= reg_a_nxt;
              state <= ACCESS;
            end else begin
              o_halt_req <= 1'b0;
              own        <= 1'b0;
              state      <= RELEASE;
            end
          end
        end
        TX_ACK: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (own) begin
              o_halt_req <= 1'b0;
              own        <= 1'b0;
              state      <= RELEASE;
            end else begin
              state <= IDLE;
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  regdbg_port_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_port_mux (
    .own            (own),
    .dbg_write_en   (commit_en),
    .dbg_add        (reg_a),
    .dbg_write_data (DATA_W'(data_buf)),
    .cpu_write_en   (i_cpu_write_en),
    .cpu_write_add  (i_cpu_write_add),
    .cpu_write_data (i_cpu_write_data),
    .cpu_read_add1  (i_cpu_read_add1),
    .rf_write_en    (o_rf_write_en),
    .rf_write_add   (o_rf_write_add),
    .rf_write_data  (o_rf_write_data),
    .rf_read_add1   (o_rf_read_add1)
  );

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// Bench for regfile_debug_ctrl: register-file and CPU halt models plus a TX/write scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_debug_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_rx_valid, i_tx_ready, i_halt_ack, i_cpu_write_en;
  logic [7:0]    i_rx_data, o_tx_data;
  logic          o_tx_valid, o_halt_req, o_rf_write_en, o_busy, o_err;
  logic [AW-1:0] i_cpu_write_add, i_cpu_read_add1, o_rf_write_add, o_rf_read_add1;
  logic [DW-1:0] i_cpu_write_data, o_rf_write_data, i_rf_read_data1;

  always #5 clk = ~clk;

  regfile_debug_ctrl #(.DATA_W(DW), .ADDR_W(AW), .HALT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_halt_req(o_halt_req), .i_halt_ack(i_halt_ack),
    .i_cpu_write_en(i_cpu_write_en), .i_cpu_write_add(i_cpu_write_add),
    .i_cpu_write_data(i_cpu_write_data), .i_cpu_read_add1(i_cpu_read_add1),
    .o_rf_write_en(o_rf_write_en), .o_rf_write_add(o_rf_write_add),
    .o_rf_write_data(o_rf_write_data), .o_rf_read_add1(o_rf_read_add1),
    .i_rf_read_data1(i_rf_read_data1), .o_busy(o_busy), .o_err(o_err)
  );

  logic [15:0] rf [16];
  logic [15:0] pre [16];
  assign i_rf_read_data1 = rf[o_rf_read_add1];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  exp_tx [$];
  logic [19:0] exp_wr [$];
  logic [19:0] wr_e;
  int          err_cnt = 0, halt_rises = 0, wr_cnt = 0;
  logic        halt_prev = 1'b0;
  int          rdy_mode = 0, ack_dly = 0, ack_cnt = 0;
  int          lat, h0, e0, w0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output int l);
    l = 1;
    while (!o_tx_valid && l < 600) begin
      tick();
      l++;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (!o_busy && exp_tx.size() == 0 && exp_wr.size() == 0) done = 1;
      else tick();
    end
    if (!done) check(tag, 0, 1);
  endtask

  // Transmitter readiness and CPU halt acknowledge (ack_dly < 0: never acks).
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = 1'($urandom_range(0, 1));
      default: i_tx_ready = 1'b0;
    endcase
    if (!o_halt_req) begin
      i_halt_ack = 1'b0;
      ack_cnt    = 0;
    end else if (ack_dly >= 0 && ack_cnt >= ack_dly) begin
      i_halt_ack = 1'b1;
    end else begin
      ack_cnt++;
    end
  end

  // Register file writes on the falling edge; debug writes occur only while halted.
  always @(negedge clk) begin
    if (reset) begin
      if (o_tx_valid && i_tx_ready) begin
        if (exp_tx.size() == 0) check("tx_extra", 1, 0);
        else check("tx_byte", o_tx_data, exp_tx.pop_front());
      end
      if (o_rf_write_en) begin
        if (o_halt_req) begin
          wr_cnt++;
          if (exp_wr.size() == 0) check("wr_extra", 1, 0);
          else begin
            wr_e = exp_wr.pop_front();
            check("wr_add", o_rf_write_add, wr_e[19:16]);
            check("wr_dat", o_rf_write_data, wr_e[15:0]);
          end
        end
        rf[o_rf_write_add] = o_rf_write_data;
      end
      if (o_err) err_cnt++;
      if (o_halt_req && !halt_prev) halt_rises++;
      halt_prev = o_halt_req;
    end
  end

  initial begin
    i_rx_valid = 0; i_rx_data = 0; i_tx_ready = 1; i_halt_ack = 0;
    i_cpu_write_en = 0; i_cpu_write_add = 0; i_cpu_write_data = 0; i_cpu_read_add1 = 0;
    for (int r = 0; r < 16; r++) pre[r] = (r == 5) ? 16'hBEEF : (16'h0F0F ^ 16'(r * 16'h1357));

    #12;
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_halt_req", o_halt_req, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_wr_en", o_rf_write_en, 0);
    @(negedge clk) reset = 1'b1;
    tick(); tick();

    // Preload through the CPU port; the mux must pass it straight through.
    for (int r = 0; r < 16; r++) begin
      i_cpu_write_en = 1; i_cpu_write_add = 4'(r); i_cpu_write_data = pre[r];
      #1;
      if (r == 5) begin
        check("pt_wr_add", o_rf_write_add, 5);
        check("pt_wr_data", o_rf_write_data, 16'hBEEF);
        check("pt_wr_en", o_rf_write_en, 1);
      end
      tick();
    end
    i_cpu_write_en = 0;

    // Write R12 = 0x1234, ack two cycles after request, random TX backpressure.
    rdy_mode = 1; ack_dly = 2; h0 = halt_rises; w0 = wr_cnt;
    exp_wr.push_back({4'hC, 16'h1234});
    exp_tx.push_back(8'hA5);
    send(8'h2C); tick(); send(8'h12); send(8'h34);
    wait_idle("wr_idle");
    pre[12] = 16'h1234;
    check("wr_once", wr_cnt - w0, 1);
    check("wr_rf", rf[12], 16'h1234);
    check("wr_halt_low", o_halt_req, 0);
    check("wr_halt_pairs", halt_rises - h0, 1);

    // Read R5 with immediate ack; CPU ports pass through around it.
    rdy_mode = 0; ack_dly = 0;
    i_cpu_read_add1 = 4'h9; #1;
    check("pt_rd_before", o_rf_read_add1, 4'h9);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    send(8'h15);
    wait_tx(lat);
    check("rd_lat", lat, 3);
    wait_idle("rd_idle");
    check("pt_rd_after", o_rf_read_add1, 4'h9);
    i_cpu_write_add = 4'h6; i_cpu_write_data = 16'hABCD; #1;
    check("pt_wr_after", {o_rf_write_add, o_rf_write_data}, {4'h6, 16'hABCD});
    i_cpu_write_add = 0; i_cpu_write_data = 0; i_cpu_read_add1 = 0;

    // Read R3 under held-off TX; a stray rx byte is dropped with an error pulse.
    rdy_mode = 2; e0 = err_cnt;
    exp_tx.push_back(pre[3][15:8]); exp_tx.push_back(pre[3][7:0]);
    send(8'h13);
    wait_tx(lat);
    tick(); tick();
    check("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, pre[3][15:8]});
    send(8'h99);
    tick();
    check("drop_err", err_cnt - e0, 1);
    rdy_mode = 0;
    wait_idle("drop_idle");

    // Halt never acknowledged: NAK after the timeout, no write.
    ack_dly = -1; e0 = err_cnt; w0 = wr_cnt;
    exp_tx.push_back(8'hEE);
    send(8'h13);
    wait_tx(lat);
    check("to_lat", lat, TO + 1);
    check("to_halt_low", o_halt_req, 0);
    check("to_err_now", o_err, 1);
    wait_idle("to_idle");
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_no_wr", wr_cnt - w0, 0);

    // Unknown opcode: NAK, error, no halt request.
    ack_dly = 0; e0 = err_cnt; h0 = halt_rises;
    exp_tx.push_back(8'hEE);
    send(8'h70);
    wait_idle("unk_idle");
    check("unk_err", err_cnt - e0, 1);
    check("unk_no_halt", halt_rises - h0, 0);

`ifdef REGDBG_DUMP_EN
    rdy_mode = 1; ack_dly = 1; h0 = halt_rises;
    for (int r = 0; r < 16; r++) begin
      exp_tx.push_back(pre[r][15:8]);
      exp_tx.push_back(pre[r][7:0]);
    end
    send(8'h30);
    wait_idle("dump_idle");
    check("dump_halt_pairs", halt_rises - h0, 1);
    check("dump_halt_low", o_halt_req, 0);
    rdy_mode = 0;
`else
    e0 = err_cnt; h0 = halt_rises;
    exp_tx.push_back(8'hEE);
    send(8'h30);
    wait_idle("dump_nak_idle");
    check("dump_nak_err", err_cnt - e0, 1);
    check("dump_nak_no_halt", halt_rises - h0, 0);
`endif

    // Reset asserted during COMMIT: outputs clear at once, write is discarded.
    rdy_mode = 2; ack_dly = 0;
    send(8'h2C); send(8'h55); send(8'h66);
    for (int i = 0; i < 50 && !o_rf_write_en; i++) tick();
    check("commit_seen", o_rf_write_en, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_outs", {o_tx_valid, o_halt_req, o_busy, o_err, o_rf_write_en}, 0);
    check("mid_rst_buses", {o_tx_data, o_rf_write_add, o_rf_write_data, o_rf_read_add1}, 0);
    exp_tx.delete(); exp_wr.delete();
    @(negedge clk) reset = 1'b1;
    halt_prev = 1'b0;
    tick(); tick();
    rdy_mode = 0;
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    send(8'h1C);
    wait_idle("post_rst_idle");
    check("post_rst_rf12", rf[12], 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
